minute_tick: RTL and testbench

Timebase and minute/second counter for the clock. It divides the millisecond clock into seconds and counts seconds and minutes. It acts as initiator of the changeHour interface: it issues rate-limited single-cycle changeHour pulses to the hours counter on every 59:59 rollover and on every manual hour-advance request. Requests are queued so the hours FSM never sees a pulse while it is busy.

---
 rtl/minute_tick.sv | 90 +++++++++
 tb/tb_minute_tick.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minute_tick.sv
// minute_tick: millisecond prescaler, second/minute counter and rate-limited changeHour initiator.
// Ports:
//    clkMSec    - system clock, rising edge
//    resetN     - asynchronous active-low reset
//    runEn      - 1 = time advances, 0 = prescaler and seconds frozen
//    setMinute  - one-cycle pulse, minute+1 (mod 60), clears second, no hour carry
//    hourAdv    - one-cycle pulse, manual hour advance request
//    second     - current second 0..59
//    minute     - current minute 0..59
//    secTick    - one-cycle pulse per second increment
//    changeHour - one-cycle pulse to the hours counter, at least GAP low cycles apart
module minute_tick #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int GAP = 4
) (
   input  logic       clkMSec,
   input  logic       resetN,
   input  logic       runEn,
   input  logic       setMinute,
   input  logic       hourAdv,
   output logic [5:0] second,
   output logic [5:0] minute,
   output logic       secTick,
   output logic       changeHour
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   logic [PW-1:0] prescaler;
   logic [1:0] state;
   logic [1:0] pending;
   logic [3:0] gapCnt;
   logic [2:0] pendSum;
   logic tick;
   logic rollReq;
   logic startPulse;
   assign tick = runEn && prescaler == TERM;
   // setMinute swallows a coincident tick, so it can never carry into the hour
   assign rollReq = tick && !setMinute && second == 6'd59 && minute == 6'd59;
   assign startPulse = pending != 2'd0 && (state == IDLE || (state == HOLD && gapCnt == 4'd0));
   // startPulse implies pending>0, so the sum never underflows; clamp only at the top
   assign pendSum = {1'b0, pending} + {2'b0, rollReq} + {2'b0, hourAdv} - {2'b0, startPulse};
   assign changeHour = state == PULSE;
   always_ff @(posedge clkMSec or negedge resetN) begin
      if (!resetN) begin
         prescaler <= '0;
         second <= 6'd0;
         minute <= 6'd0;
         secTick <= 1'b0;
      end else begin
         secTick <= 1'b0;
         if (setMinute) begin
            minute <= minute == 6'd59 ? 6'd0 : minute + 6'd1;
            second <= 6'd0;
            prescaler <= '0;
         end else if (tick) begin
            prescaler <= '0;
            secTick <= 1'b1;
            second <= second == 6'd59 ? 6'd0 : second + 6'd1;
            if (second == 6'd59) minute <= minute == 6'd59 ? 6'd0 : minute + 6'd1;
         end else if (runEn) begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end
   always_ff @(posedge clkMSec or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
         pending <= 2'd0;
         gapCnt <= 4'd0;
      end else begin
         pending <= pendSum > 3'd3 ? 2'd3 : pendSum[1:0];
         case (state)
            IDLE: state <= startPulse ? PULSE : IDLE;
            PULSE: begin
               state <= HOLD;
               gapCnt <= GAP_LOAD;
            end
            HOLD: begin
               if (gapCnt != 4'd0) gapCnt <= gapCnt - 4'd1;
               else state <= startPulse ? PULSE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_minute_tick.sv
// tb_minute_tick: randomized and directed checks of minute_tick against a time-of-day model.
// Ports: none (top-level bench driving clkMSec, resetN, runEn, setMinute, hourAdv).
module tb_minute_tick;
   localparam int TPS = 4;
   localparam int GAP = 4;
   logic clkMSec, resetN, runEn, setMinute, hourAdv;
   logic [5:0] second, minute;
   logic secTick, changeHour;
   int nCmp = 0;
   int nBad = 0;
   // model: time of day in seconds, ms ticks within the second, queued hour requests
   int mTod, mTicks, mPend, cycN, nextOk;
   logic mSecTick, mChange;

   minute_tick #(.TICKS_PER_SEC(TPS), .GAP(GAP)) dut (
      .clkMSec(clkMSec), .resetN(resetN), .runEn(runEn), .setMinute(setMinute),
      .hourAdv(hourAdv), .second(second), .minute(minute), .secTick(secTick),
      .changeHour(changeHour)
   );

   initial clkMSec = 1'b0;
   always #5 clkMSec = ~clkMSec;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [13:0] expVec();
      return {6'(mTod % 60), 6'(mTod / 60), mSecTick, mChange};
   endfunction

   task automatic modelReset();
      mTod = 0; mTicks = 0; mPend = 0; cycN = 0; nextOk = 0;
      mSecTick = 1'b0; mChange = 1'b0;
   endtask

   // one clock edge of the model: a pulse may issue whenever a request is waiting
   // and at least GAP+1 cycles have passed since the previous pulse
   task automatic modelEdge(input logic r, input logic s, input logic a);
      int roll = 0;
      logic pulse;
      cycN++;
      pulse = mPend > 0 && cycN >= nextOk;
      if (pulse) nextOk = cycN + GAP + 1;
      mSecTick = 1'b0;
      if (s) begin
         mTod = ((mTod / 60 + 1) % 60) * 60;
         mTicks = 0;
      end else if (r) begin
         mTicks++;
         if (mTicks == TPS) begin
            mTicks = 0;
            mSecTick = 1'b1;
            mTod = (mTod + 1) % 3600;
            roll = mTod == 0 ? 1 : 0;
         end
      end
      mPend = mPend - (pulse ? 1 : 0) + roll + (a ? 1 : 0);
      if (mPend > 3) mPend = 3;
      mChange = pulse;
   endtask

   task automatic cyc(input logic r, input logic s, input logic a);
      runEn = r; setMinute = s; hourAdv = a;
      @(posedge clkMSec);
      modelEdge(r, s, a);
      #1;
   endtask

   task automatic assertRst();
      runEn = 0; setMinute = 0; hourAdv = 0; resetN = 0;
      #1;
      modelReset();
   endtask

   task automatic releaseRst();
      @(posedge clkMSec);
      #1;
      resetN = 1;
   endtask

   task automatic test_reset();
      assertRst();
      nCmp++;
      if ({second, minute, secTick, changeHour} !== 14'd0) begin
         nBad++;
         $display("FAIL reset: got %h want 0", {second, minute, secTick, changeHour});
      end
      releaseRst();
   endtask

   task automatic test_run_minute();
      int ticks = 0, pulses = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 240; i++) begin
         cyc(1, 0, 0);
         ticks += secTick;
         pulses += changeHour;
         nCmp++;
         if ({second, minute, secTick, changeHour} !== expVec()) begin
            nBad++;
            $display("FAIL run_minute cyc %0d: got %h want %h", i, {second, minute, secTick, changeHour}, expVec());
         end
      end
      nCmp++;
      if (minute !== 6'd1 || second !== 6'd0) begin
         nBad++;
         $display("FAIL run_minute end: got %0d:%0d want 1:0", minute, second);
      end
      nCmp++;
      if (ticks != 60 || pulses != 0) begin
         nBad++;
         $display("FAIL run_minute counts: got %0d ticks %0d pulses want 60 ticks 0 pulses", ticks, pulses);
      end
   endtask

   task automatic test_rollover();
      logic [5:0] pm, ps;
      int found = 0, extra = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 59; i++) cyc(1, 1, 0);
      nCmp++;
      if (minute !== 6'd59 || second !== 6'd0) begin
         nBad++;
         $display("FAIL rollover setup: got %0d:%0d want 59:0", minute, second);
      end
      for (int i = 0; i < 300 && found == 0; i++) begin
         pm = minute; ps = second;
         cyc(1, 0, 0);
         if (pm == 6'd59 && minute == 6'd0) found = 1;
      end
      nCmp++;
      if (found == 0 || ps !== 6'd59 || second !== 6'd0) begin
         nBad++;
         $display("FAIL rollover wrap: found %0d prev sec %0d sec %0d want 1 59 0", found, ps, second);
      end
      cyc(1, 0, 0);
      nCmp++;
      if (changeHour !== 1'b1) begin
         nBad++;
         $display("FAIL rollover pulse: got %b want 1", changeHour);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 0);
         extra += changeHour;
      end
      nCmp++;
      if (extra != 0) begin
         nBad++;
         $display("FAIL rollover single: got %0d extra pulses want 0", extra);
      end
   endtask

   task automatic test_adv_with_rollover();
      int q[$];
      assertRst(); releaseRst();
      for (int i = 0; i < 59; i++) cyc(1, 1, 0);
      for (int i = 0; i < 400 && !(mTod == 3599 && mTicks == TPS - 1); i++) cyc(1, 0, 0);
      cyc(1, 0, 1);
      nCmp++;
      if (minute !== 6'd0 || second !== 6'd0) begin
         nBad++;
         $display("FAIL adv_roll wrap: got %0d:%0d want 0:0", minute, second);
      end
      for (int i = 0; i < 30; i++) begin
         cyc(1, 0, 0);
         if (changeHour) q.push_back(cycN);
         nCmp++;
         if ({second, minute, secTick, changeHour} !== expVec()) begin
            nBad++;
            $display("FAIL adv_roll cyc %0d: got %h want %h", i, {second, minute, secTick, changeHour}, expVec());
         end
      end
      nCmp++;
      if (q.size() != 2 || q[1] - q[0] != GAP + 1) begin
         nBad++;
         $display("FAIL adv_roll pulses: got %0d pulses spacing %0d want 2 spacing %0d", q.size(), q.size() == 2 ? q[1] - q[0] : -1, GAP + 1);
      end
   endtask

   task automatic test_back_to_back();
      int q[$];
      int badGap = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1);
         if (changeHour) q.push_back(cycN);
      end
      for (int i = 0; i < 40; i++) begin
         cyc(0, 0, 0);
         if (changeHour) q.push_back(cycN);
         nCmp++;
         if (changeHour !== mChange) begin
            nBad++;
            $display("FAIL back_to_back cyc %0d: got %b want %b", i, changeHour, mChange);
         end
      end
      for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != GAP + 1) badGap++;
      nCmp++;
      if (q.size() != 4 || badGap != 0) begin
         nBad++;
         $display("FAIL back_to_back count: got %0d pulses %0d bad gaps want 4 pulses 0 bad gaps", q.size(), badGap);
      end
   endtask

   task automatic test_set_at_terminal();
      int pulses = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 59; i++) cyc(0, 1, 0);
      for (int i = 0; i < 10 && mTicks != TPS - 1; i++) cyc(1, 0, 0);
      cyc(1, 1, 0);
      nCmp++;
      if ({minute, second, secTick} !== 13'd0) begin
         nBad++;
         $display("FAIL set_terminal: got %0d:%0d tick %b want 0:0 tick 0", minute, second, secTick);
      end
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0);
         pulses += changeHour;
      end
      nCmp++;
      if (pulses != 0) begin
         nBad++;
         $display("FAIL set_terminal pulses: got %0d want 0", pulses);
      end
   endtask

   task automatic test_freeze();
      int moved = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      for (int i = 0; i < 100; i++) begin
         cyc(0, 0, 0);
         if (second !== 6'd1 || secTick !== 1'b0) moved++;
      end
      nCmp++;
      if (moved != 0) begin
         nBad++;
         $display("FAIL freeze: got %0d changed cycles want 0", moved);
      end
      cyc(1, 0, 0);
      nCmp++;
      if (secTick !== 1'b0 || second !== 6'd1) begin
         nBad++;
         $display("FAIL freeze resume1: got sec %0d tick %b want 1 0", second, secTick);
      end
      cyc(1, 0, 0);
      nCmp++;
      if (secTick !== 1'b1 || second !== 6'd2) begin
         nBad++;
         $display("FAIL freeze resume2: got sec %0d tick %b want 2 1", second, secTick);
      end
   endtask

   task automatic test_reset_in_hold();
      int pulses = 0;
      assertRst(); releaseRst();
      for (int i = 0; i < 9; i++) cyc(1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1);
      #2;
      assertRst();
      nCmp++;
      if ({second, minute, secTick, changeHour} !== 14'd0) begin
         nBad++;
         $display("FAIL hold_reset: got %h want 0", {second, minute, secTick, changeHour});
      end
      releaseRst();
      for (int i = 0; i < 30; i++) begin
         cyc(0, 0, 0);
         pulses += changeHour;
      end
      nCmp++;
      if (pulses != 0) begin
         nBad++;
         $display("FAIL hold_reset stale: got %0d pulses want 0", pulses);
      end
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      nCmp++;
      if (changeHour !== 1'b1) begin
         nBad++;
         $display("FAIL hold_reset new: got %b want 1", changeHour);
      end
   endtask

   task automatic test_random();
      assertRst(); releaseRst();
      for (int i = 0; i < 5000; i++) begin
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0);
         nCmp++;
         if ({second, minute, secTick, changeHour} !== expVec()) begin
            nBad++;
            $display("FAIL random cyc %0d: got %h want %h", i, {second, minute, secTick, changeHour}, expVec());
         end
      end
   endtask

   initial begin
      resetN = 1; runEn = 0; setMinute = 0; hourAdv = 0;
      modelReset();
      test_reset();
      test_run_minute();
      test_rollover();
      test_adv_with_rollover();
      test_back_to_back();
      test_set_at_terminal();
      test_freeze();
      test_reset_in_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
